ibex_fetch_req_ctrl: RTL and testbench
======================================

Name: ibex_fetch_req_ctrl

Overview:
Instruction-side bus request sequencer sitting directly upstream of the fetch FIFO. It issues word-aligned instruction fetches with up to NUM_REQS outstanding and throttles them on FIFO fill level. It computes CHERI PCC bounds errors per request, tags responses, and discards responses made stale by a branch. It then pushes surviving responses plus their error flags into the FIFO's input port.

Parameters:
NUM_REQS, 2, maximum outstanding bus requests; must equal the FIFO's NUM_REQS
ResetAll, 1'b0, when 1 all datapath flops are also reset (control flops always reset)

Ports:
clk_i  in  1  clock
rst_ni  in  1  synchronous active-low reset
req_i  in  1  fetching enabled; when 0 no new request is started
branch_i  in  1  redirect pulse, one cycle
branch_addr_i  in  32  redirect target, halfword aligned
pcc_base_i  in  32  PCC lower bound (inclusive)
pcc_top_i  in  33  PCC upper bound (exclusive)
pcc_exc_i  in  ibex_pkg::cheri_instr_exc_t  non-length PCC exceptions (tag, seal, perm), sampled at grant
fifo_busy_i  in  NUM_REQS  FIFO busy_o
fifo_clear_o  out  1  FIFO clear_i
fifo_valid_o  out  1  FIFO in_valid_i
fifo_addr_o  out  32  FIFO in_addr_i
fifo_rdata_o  out  32  FIFO in_rdata_i
fifo_err_o  out  1  FIFO in_err_i
fifo_cheri_err_o  out  cheri_instr_exc_t  FIFO in_cheri_err_i
fifo_cheri_lower_err_o  out  1  FIFO in_cheri_lower_err_i
fifo_cheri_upper_err_o  out  1  FIFO in_cheri_upper_err_i
fifo_cheri_upper_err_2_o  out  1  tied to fifo_cheri_upper_err_o (non-TestRIG build)
instr_req_o  out  1  bus request
instr_gnt_i  in  1  bus grant
instr_addr_o  out  32  bus address, [1:0]=2'b00
instr_rvalid_i  in  1  response valid
instr_rdata_i  in  32  response data
instr_err_i  in  1  bus error
busy_o  out  1  any request outstanding or pending

Behaviour:
- Reset values:
  - instr_req_o=0; all fifo_* valid/clear outputs 0.
  - fetch_addr_q=0; outstanding count 0; discard mask 0; state IDLE; busy_o=0.
- Address handling:
  - fifo_clear_o=branch_i (combinational).
  - fifo_addr_o=branch_addr_i.
  - On branch_i, fetch_addr_q <= {branch_addr_i[31:2],2'b00}.
  - fetch_addr_q increments by 4 (mod 2^32, wraps silently) on each grant that is not superseded.
- Issue condition (issue_ok):
  - req_i, outstanding < NUM_REQS, and fifo_busy_i[NUM_REQS-1-outstanding]==0 (slots in FIFO cover all in-flight responses).
  - Throttling is evaluated only when starting a request.
- FSM IDLE: instr_req_o=issue_ok, instr_addr_o = branch_i ? aligned branch_addr_i : fetch_addr_q.
  - Request with gnt -> stay IDLE.
  - Request without gnt -> WAIT_GNT; latch addr_pend_q.
- FSM WAIT_GNT: instr_req_o=1, instr_addr_o=addr_pend_q, held stable until gnt (OBI rule; never deassert or change before gnt).
  - On gnt -> IDLE.
  - branch_i in WAIT_GNT: mark this request discard-on-response; store the branch target in fetch_addr_q. The first request to the target is issued in the cycle after the grant.
- Outstanding tracking:
  - Per-slot shift/queue of {discard, lower_err, upper_err, pcc_exc} of depth NUM_REQS, pushed at grant, popped at rvalid.
  - Grant and rvalid in the same cycle: push and pop together, count unchanged.
  - branch_i sets discard on every occupied slot, including a slot pushed in the same cycle.
- Bounds check at grant, addr A, 33-bit arithmetic:
  - lower_err = (A < pcc_base_i) | (A+2 > pcc_top_i).
  - upper_err = (A+2 < pcc_base_i) | (A+4 > pcc_top_i).
- Response:
  - fifo_valid_o = instr_rvalid_i & ~head.discard & ~branch_i.
  - Data and error outputs pass through combinationally, giving zero-cycle latency rvalid -> FIFO push.
  - rvalid with count 0 is illegal (assertion).
- Reset mid-operation: all state cleared; later rvalids for lost requests are the bus's responsibility (bus reset together).
- busy_o = (outstanding != 0) | (state==WAIT_GNT).

Decomposition:
- ibex_pkg gains typedef fetch_req_tag_t {discard, lower_err, upper_err, cheri_instr_exc_t exc}.
- One sub-module, ibex_fetch_req_tag_fifo: NUM_REQS-deep tag queue with push/pop/flag-all-discard.
- FSM, address counter and bounds check stay in the top module.

Test Plan:
- Reset, req_i=1, base 0, top 0x1000, gnt immediate, rvalid one cycle later -> addresses 0x0, 0x4; two pushes with all errs 0; never more than 2 outstanding.
- Hold gnt=0 for 3 cycles at 0x8 with branch_i to 0x102 in cycle 2 -> instr_addr_o stays 0x8 until gnt. Response discarded (fifo_valid_o=0). Next request is 0x100; fifo_clear_o pulses in cycle 2.
- pcc_top_i=0x1002, fetch at 0x1000 -> lower_err=0, upper_err=1. Fetch at 0x1004 -> both 1.
- fifo_busy_i=2'b01 with 1 outstanding -> instr_req_o=0. It reasserts the cycle after busy clears.
- Simultaneous gnt and rvalid at steady state -> outstanding count constant, every response pushed in order, no tag mismatch.
- Fetch address 0xFFFFFFFC, grant -> next address 0x00000000; branch_i on the same cycle as rvalid -> that rvalid not pushed.

Source files
------------

// File: rtl/ibex_pkg.sv
// Shared types for the instruction-fetch request path: PCC exception flags,
// per-request tags carried from grant to response, and the request FSM states.
package ibex_pkg;

   typedef struct packed {
      logic tag_err;
      logic seal_err;
      logic perm_err;
   } cheri_instr_exc_t;

   typedef struct packed {
      logic             discard;
      logic             lower_err;
      logic             upper_err;
      cheri_instr_exc_t exc;
   } fetch_req_tag_t;

   typedef enum logic {
      FETCH_IDLE,
      FETCH_WAIT_GNT
   } fetch_req_state_e;

   // Returns {lower_err, upper_err}: the two halfwords of the fetched word
   // checked against [base, top) in 33-bit arithmetic so top=2^32 is usable.
   function automatic logic [1:0] pcc_bounds_chk(input logic [31:0] addr,
                                                 input logic [31:0] base,
                                                 input logic [32:0] top);
      logic [32:0] a;
      logic [32:0] b;
      logic        lower;
      logic        upper;
      a     = {1'b0, addr};
      b     = {1'b0, base};
      lower = (a < b) | ((a + 33'd2) > top);
      upper = ((a + 33'd2) < b) | ((a + 33'd4) > top);
      return {lower, upper};
   endfunction

endpackage

// File: rtl/ibex_fetch_req_tag_fifo.sv
// Tag queue for in-flight fetches: pushed at grant, popped at response,
// with a broadcast that marks every queued request as stale.
module ibex_fetch_req_tag_fifo
   import ibex_pkg::*;
#(
   parameter int unsigned NUM_REQS = 2,
   parameter bit          ResetAll = 1'b0
) (
   input  logic                              clk_i,
   input  logic                              rst_ni,
   input  logic                              push_i,
   input  fetch_req_tag_t                    push_tag_i,
   input  logic                              pop_i,
   input  logic                              discard_all_i,
   output fetch_req_tag_t                    head_o,
   output logic [$clog2(NUM_REQS+1)-1:0]     cnt_o
);

   localparam int unsigned CntW = $clog2(NUM_REQS + 1);

   fetch_req_tag_t  entries_q [NUM_REQS];
   fetch_req_tag_t  entries_d [NUM_REQS];
   logic [CntW-1:0] cnt_q;
   logic [CntW-1:0] cnt_d;

   // Pop first, then flag survivors stale, then append; a push in the same
   // cycle as a discard broadcast carries its own discard bit from the caller.
   always_comb begin
      entries_d = entries_q;
      cnt_d     = cnt_q;
      if (pop_i && (cnt_q != '0)) begin
         for (int i = 0; i < NUM_REQS - 1; i++) begin
            entries_d[i] = entries_q[i+1];
         end
         cnt_d = cnt_q - CntW'(1);
      end
      if (discard_all_i) begin
         for (int i = 0; i < NUM_REQS; i++) begin
            if (CntW'(i) < cnt_d) entries_d[i].discard = 1'b1;
         end
      end
      if (push_i && (cnt_d < CntW'(NUM_REQS))) begin
         for (int i = 0; i < NUM_REQS; i++) begin
            if (CntW'(i) == cnt_d) entries_d[i] = push_tag_i;
         end
         cnt_d = cnt_d + CntW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cnt_q <= '0;
         if (ResetAll) entries_q <= '{default: '0};
      end else begin
         cnt_q     <= cnt_d;
         entries_q <= entries_d;
      end
   end

   assign head_o = entries_q[0];
   assign cnt_o  = cnt_q;

endmodule

// File: rtl/ibex_fetch_req_ctrl.sv
// Instruction bus request sequencer feeding the fetch FIFO: issues aligned
// fetches, checks PCC bounds per request and drops responses made stale by branches.
//   state          | meaning
//   FETCH_IDLE     | no request pending; may start one this cycle
//   FETCH_WAIT_GNT | request on bus without grant; address held stable
module ibex_fetch_req_ctrl
   import ibex_pkg::*;
#(
   parameter int unsigned NUM_REQS = 2,
   parameter bit          ResetAll = 1'b0
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  req_i,
   input  logic                  branch_i,
   input  logic [31:0]           branch_addr_i,
   input  logic [31:0]           pcc_base_i,
   input  logic [32:0]           pcc_top_i,
   input  cheri_instr_exc_t      pcc_exc_i,
   input  logic [NUM_REQS-1:0]   fifo_busy_i,
   output logic                  fifo_clear_o,
   output logic                  fifo_valid_o,
   output logic [31:0]           fifo_addr_o,
   output logic [31:0]           fifo_rdata_o,
   output logic                  fifo_err_o,
   output cheri_instr_exc_t      fifo_cheri_err_o,
   output logic                  fifo_cheri_lower_err_o,
   output logic                  fifo_cheri_upper_err_o,
   output logic                  fifo_cheri_upper_err_2_o,
   output logic                  instr_req_o,
   input  logic                  instr_gnt_i,
   output logic [31:0]           instr_addr_o,
   input  logic                  instr_rvalid_i,
   input  logic [31:0]           instr_rdata_i,
   input  logic                  instr_err_i,
   output logic                  busy_o
);

   localparam int unsigned CntW = $clog2(NUM_REQS + 1);

   fetch_req_state_e state_q, state_d;
   logic [31:0]      fetch_addr_q, fetch_addr_d;
   logic [31:0]      addr_pend_q, addr_pend_d;
   logic             pend_discard_q, pend_discard_d;
   logic [CntW-1:0]  out_cnt;
   fetch_req_tag_t   head_tag;
   fetch_req_tag_t   push_tag;
   logic             push;
   logic             push_discard;
   logic             slot_busy;
   logic             issue_ok;
   logic [1:0]       bnd_err;
   logic [31:0]      branch_aligned;

   assign branch_aligned = {branch_addr_i[31:2], 2'b00};

   // The FIFO must have room for every response already in flight plus this one.
   always_comb begin
      slot_busy = 1'b0;
      for (int i = 0; i < NUM_REQS; i++) begin
         if (out_cnt == CntW'(NUM_REQS - 1 - i)) slot_busy = fifo_busy_i[i];
      end
   end

   assign issue_ok = req_i & (out_cnt < CntW'(NUM_REQS)) & ~slot_busy;

   always_comb begin
      state_d        = state_q;
      fetch_addr_d   = fetch_addr_q;
      addr_pend_d    = addr_pend_q;
      pend_discard_d = pend_discard_q;
      instr_req_o    = 1'b0;
      instr_addr_o   = fetch_addr_q;
      push           = 1'b0;
      push_discard   = 1'b0;
      case (state_q)
         FETCH_IDLE: begin
            instr_addr_o = branch_i ? branch_aligned : fetch_addr_q;
            instr_req_o  = issue_ok;
            if (branch_i) fetch_addr_d = branch_aligned;
            if (issue_ok) begin
               if (instr_gnt_i) begin
                  push         = 1'b1;
                  fetch_addr_d = instr_addr_o + 32'd4;
               end else begin
                  state_d        = FETCH_WAIT_GNT;
                  addr_pend_d    = instr_addr_o;
                  pend_discard_d = 1'b0;
               end
            end
         end
         FETCH_WAIT_GNT: begin
            instr_req_o  = 1'b1;
            instr_addr_o = addr_pend_q;
            if (branch_i) begin
               fetch_addr_d   = branch_aligned;
               pend_discard_d = 1'b1;
            end
            if (instr_gnt_i) begin
               push           = 1'b1;
               push_discard   = pend_discard_q | branch_i;
               state_d        = FETCH_IDLE;
               pend_discard_d = 1'b0;
               if (!(pend_discard_q | branch_i)) fetch_addr_d = addr_pend_q + 32'd4;
            end
         end
         default: state_d = FETCH_IDLE;
      endcase
   end

   assign bnd_err  = pcc_bounds_chk(instr_addr_o, pcc_base_i, pcc_top_i);
   assign push_tag = '{discard:   push_discard,
                       lower_err: bnd_err[1],
                       upper_err: bnd_err[0],
                       exc:       pcc_exc_i};

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q        <= FETCH_IDLE;
         fetch_addr_q   <= '0;
         pend_discard_q <= 1'b0;
         if (ResetAll) addr_pend_q <= '0;
      end else begin
         state_q        <= state_d;
         fetch_addr_q   <= fetch_addr_d;
         pend_discard_q <= pend_discard_d;
         addr_pend_q    <= addr_pend_d;
      end
   end

   ibex_fetch_req_tag_fifo #(
      .NUM_REQS (NUM_REQS),
      .ResetAll (ResetAll)
   ) u_tag_fifo (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .push_i        (push),
      .push_tag_i    (push_tag),
      .pop_i         (instr_rvalid_i),
      .discard_all_i (branch_i),
      .head_o        (head_tag),
      .cnt_o         (out_cnt)
   );

   assign fifo_clear_o             = branch_i;
   assign fifo_addr_o              = branch_addr_i;
   assign fifo_valid_o             = instr_rvalid_i & ~head_tag.discard & ~branch_i;
   assign fifo_rdata_o             = instr_rdata_i;
   assign fifo_err_o               = instr_err_i;
   assign fifo_cheri_err_o         = head_tag.exc;
   assign fifo_cheri_lower_err_o   = head_tag.lower_err;
   assign fifo_cheri_upper_err_o   = head_tag.upper_err;
   assign fifo_cheri_upper_err_2_o = head_tag.upper_err;
   assign busy_o                   = (out_cnt != '0) | (state_q == FETCH_WAIT_GNT);

   rvalid_needs_outstanding_a : assert property (
      @(posedge clk_i) disable iff (!rst_ni) instr_rvalid_i |-> (out_cnt != '0));

endmodule

// File: tb/tb_ibex_fetch_req_ctrl.sv
// Cycle-table bench for the fetch request sequencer plus hand sequences for
// back-to-back grant/response ordering and reset with requests in flight.
module tb_ibex_fetch_req_ctrl;
   import ibex_pkg::*;

   logic             clk_i = 1'b0;
   logic             rst_ni;
   logic             req_i, branch_i, instr_gnt_i, instr_rvalid_i, instr_err_i;
   logic [31:0]      branch_addr_i, pcc_base_i, instr_rdata_i;
   logic [32:0]      pcc_top_i;
   cheri_instr_exc_t pcc_exc_i;
   logic [1:0]       fifo_busy_i;
   logic             fifo_clear_o, fifo_valid_o, fifo_err_o;
   logic [31:0]      fifo_addr_o, fifo_rdata_o, instr_addr_o;
   cheri_instr_exc_t fifo_cheri_err_o;
   logic             fifo_cheri_lower_err_o, fifo_cheri_upper_err_o, fifo_cheri_upper_err_2_o;
   logic             instr_req_o, busy_o;

   always #5 clk_i = ~clk_i;

   ibex_fetch_req_ctrl #(.NUM_REQS(2), .ResetAll(1'b0)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .branch_i(branch_i),
      .branch_addr_i(branch_addr_i), .pcc_base_i(pcc_base_i), .pcc_top_i(pcc_top_i),
      .pcc_exc_i(pcc_exc_i), .fifo_busy_i(fifo_busy_i), .fifo_clear_o(fifo_clear_o),
      .fifo_valid_o(fifo_valid_o), .fifo_addr_o(fifo_addr_o), .fifo_rdata_o(fifo_rdata_o),
      .fifo_err_o(fifo_err_o), .fifo_cheri_err_o(fifo_cheri_err_o),
      .fifo_cheri_lower_err_o(fifo_cheri_lower_err_o),
      .fifo_cheri_upper_err_o(fifo_cheri_upper_err_o),
      .fifo_cheri_upper_err_2_o(fifo_cheri_upper_err_2_o),
      .instr_req_o(instr_req_o), .instr_gnt_i(instr_gnt_i), .instr_addr_o(instr_addr_o),
      .instr_rvalid_i(instr_rvalid_i), .instr_rdata_i(instr_rdata_i),
      .instr_err_i(instr_err_i), .busy_o(busy_o)
   );

   typedef struct packed {
      logic        req;
      logic        gnt;
      logic        rv;
      logic        br;
      logic [31:0] baddr;
      logic [1:0]  fbusy;
      logic [32:0] top;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_valid;
      logic        e_clear;
      logic        e_lo;
      logic        e_up;
      logic        e_busy;
   } vec_t;

   int errors = 0;
   int checks = 0;

   function automatic vec_t mk(input logic req, gnt, rv, br, input logic [31:0] baddr,
                               input logic [1:0] fbusy, input logic [32:0] top,
                               input logic e_req, input logic [31:0] e_addr,
                               input logic e_valid, e_clear, e_lo, e_up, e_busy);
      vec_t v;
      v = '{req, gnt, rv, br, baddr, fbusy, top, e_req, e_addr, e_valid, e_clear, e_lo, e_up, e_busy};
      return v;
   endfunction

   task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t             vq[$];
      vec_t             v;
      cheri_instr_exc_t ex [7];
      logic [32:0]      t0, t1, tb;
      t0 = 33'h0_0000_1000;
      t1 = 33'h0_0000_1002;
      tb = 33'h1_0000_0000;

      //               req gnt rv br baddr         fb  top  e_req e_addr        v  clr lo up busy
      vq.push_back(mk(1, 1, 0, 0, 32'h0,        2'b00, t0, 1, 32'h0,        0, 0, 0, 0, 0));
      vq.push_back(mk(1, 1, 1, 0, 32'h0,        2'b00, t0, 1, 32'h4,        1, 0, 0, 0, 1));
      vq.push_back(mk(1, 1, 1, 0, 32'h0,        2'b00, t0, 1, 32'h8,        1, 0, 0, 0, 1));
      vq.push_back(mk(0, 0, 1, 0, 32'h0,        2'b00, t0, 0, 32'hC,        1, 0, 0, 0, 1));
      vq.push_back(mk(0, 0, 0, 0, 32'h0,        2'b00, t0, 0, 32'hC,        0, 0, 0, 0, 0));
      vq.push_back(mk(1, 1, 0, 0, 32'h0,        2'b00, t0, 1, 32'hC,        0, 0, 0, 0, 0));
      vq.push_back(mk(1, 1, 0, 0, 32'h0,        2'b00, t0, 1, 32'h10,       0, 0, 0, 0, 1));
      vq.push_back(mk(1, 0, 0, 0, 32'h0,        2'b00, t0, 0, 32'h14,       0, 0, 0, 0, 1));
      vq.push_back(mk(1, 0, 1, 0, 32'h0,        2'b00, t0, 0, 32'h14,       1, 0, 0, 0, 1));
      vq.push_back(mk(0, 0, 1, 0, 32'h0,        2'b00, t0, 0, 32'h14,       1, 0, 0, 0, 1));
      vq.push_back(mk(0, 0, 0, 1, 32'h8,        2'b00, t0, 0, 32'h8,        0, 1, 0, 0, 0));
      vq.push_back(mk(1, 0, 0, 0, 32'h0,        2'b00, t0, 1, 32'h8,        0, 0, 0, 0, 0));
      vq.push_back(mk(1, 0, 0, 0, 32'h0,        2'b00, t0, 1, 32'h8,        0, 0, 0, 0, 1));
      vq.push_back(mk(1, 0, 0, 1, 32'h102,      2'b00, t0, 1, 32'h8,        0, 1, 0, 0, 1));
      vq.push_back(mk(1, 0, 0, 0, 32'h0,        2'b00, t0, 1, 32'h8,        0, 0, 0, 0, 1));
      vq.push_back(mk(1, 1, 0, 0, 32'h0,        2'b00, t0, 1, 32'h8,        0, 0, 0, 0, 1));
      vq.push_back(mk(1, 1, 1, 0, 32'h0,        2'b00, t0, 1, 32'h100,      0, 0, 0, 0, 1));
      vq.push_back(mk(0, 0, 1, 0, 32'h0,        2'b00, t0, 0, 32'h104,      1, 0, 0, 0, 1));
      vq.push_back(mk(0, 0, 0, 1, 32'h1000,     2'b00, t1, 0, 32'h1000,     0, 1, 0, 0, 0));
      vq.push_back(mk(1, 1, 0, 0, 32'h0,        2'b00, t1, 1, 32'h1000,     0, 0, 0, 0, 0));
      vq.push_back(mk(1, 1, 1, 0, 32'h0,        2'b00, t1, 1, 32'h1004,     1, 0, 0, 1, 1));
      vq.push_back(mk(0, 0, 1, 0, 32'h0,        2'b00, t1, 0, 32'h1008,     1, 0, 1, 1, 1));
      vq.push_back(mk(1, 1, 0, 0, 32'h0,        2'b00, tb, 1, 32'h1008,     0, 0, 0, 0, 0));
      vq.push_back(mk(1, 0, 0, 0, 32'h0,        2'b01, tb, 0, 32'h100C,     0, 0, 0, 0, 1));
      vq.push_back(mk(1, 0, 0, 0, 32'h0,        2'b01, tb, 0, 32'h100C,     0, 0, 0, 0, 1));
      vq.push_back(mk(1, 1, 0, 0, 32'h0,        2'b00, tb, 1, 32'h100C,     0, 0, 0, 0, 1));
      vq.push_back(mk(0, 0, 1, 0, 32'h0,        2'b00, tb, 0, 32'h1010,     1, 0, 0, 0, 1));
      vq.push_back(mk(0, 0, 1, 0, 32'h0,        2'b00, tb, 0, 32'h1010,     1, 0, 0, 0, 1));
      vq.push_back(mk(1, 1, 0, 1, 32'hFFFFFFFE, 2'b00, tb, 1, 32'hFFFFFFFC, 0, 1, 0, 0, 0));
      vq.push_back(mk(0, 0, 0, 0, 32'h0,        2'b00, tb, 0, 32'h0,        0, 0, 0, 0, 1));
      vq.push_back(mk(0, 0, 1, 1, 32'h40,       2'b00, tb, 0, 32'h40,       0, 1, 0, 0, 1));
      vq.push_back(mk(0, 0, 0, 0, 32'h0,        2'b00, tb, 0, 32'h40,       0, 0, 0, 0, 0));

      rst_ni = 1'b0; req_i = 1'b0; branch_i = 1'b0; branch_addr_i = '0;
      pcc_base_i = '0; pcc_top_i = t0; pcc_exc_i = '0; fifo_busy_i = '0;
      instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0; instr_rdata_i = '0; instr_err_i = 1'b0;
      repeat (2) @(negedge clk_i);
      #1;
      chk("reset req",   33'(instr_req_o),  33'd0);
      chk("reset busy",  33'(busy_o),       33'd0);
      chk("reset valid", 33'(fifo_valid_o), 33'd0);
      chk("reset clear", 33'(fifo_clear_o), 33'd0);
      chk("reset addr",  33'(instr_addr_o), 33'd0);

      for (int i = 0; i < vq.size(); i++) begin
         v = vq[i];
         @(negedge clk_i);
         rst_ni         = 1'b1;
         req_i          = v.req;
         instr_gnt_i    = v.gnt;
         instr_rvalid_i = v.rv;
         branch_i       = v.br;
         branch_addr_i  = v.baddr;
         fifo_busy_i    = v.fbusy;
         pcc_top_i      = v.top;
         instr_rdata_i  = 32'hD000_0000 + 32'(i);
         #1;
         chk($sformatf("row%0d req", i),   33'(instr_req_o),  33'(v.e_req));
         chk($sformatf("row%0d addr", i),  33'(instr_addr_o), 33'(v.e_addr));
         chk($sformatf("row%0d valid", i), 33'(fifo_valid_o), 33'(v.e_valid));
         chk($sformatf("row%0d clear", i), 33'(fifo_clear_o), 33'(v.e_clear));
         chk($sformatf("row%0d busy", i),  33'(busy_o),       33'(v.e_busy));
         if (v.e_valid) begin
            chk($sformatf("row%0d lower_err", i), 33'(fifo_cheri_lower_err_o), 33'(v.e_lo));
            chk($sformatf("row%0d upper_err", i), 33'(fifo_cheri_upper_err_o), 33'(v.e_up));
            chk($sformatf("row%0d upper_err_2", i), 33'(fifo_cheri_upper_err_2_o), 33'(v.e_up));
            chk($sformatf("row%0d rdata", i), 33'(fifo_rdata_o), 33'(32'hD000_0000 + 32'(i)));
         end
      end

      // back-to-back grant and response: tags must come out in grant order
      for (int k = 0; k < 7; k++) ex[k] = cheri_instr_exc_t'(3'((k * 5 + 3) % 8));
      @(negedge clk_i);
      req_i = 1'b1; instr_gnt_i = 1'b1; instr_rvalid_i = 1'b0; branch_i = 1'b0;
      branch_addr_i = '0; pcc_top_i = tb; pcc_exc_i = ex[0];
      #1;
      chk("steady first addr", 33'(instr_addr_o), 33'h40);
      for (int k = 1; k < 7; k++) begin
         @(negedge clk_i);
         pcc_exc_i = ex[k]; instr_rvalid_i = 1'b1;
         instr_rdata_i = 32'hA500_0000 + 32'(k); instr_err_i = k[0];
         #1;
         chk($sformatf("steady%0d req", k),   33'(instr_req_o),  33'd1);
         chk($sformatf("steady%0d addr", k),  33'(instr_addr_o), 33'(32'h40 + 32'(4 * k)));
         chk($sformatf("steady%0d valid", k), 33'(fifo_valid_o), 33'd1);
         chk($sformatf("steady%0d err", k),   33'(fifo_err_o),   33'(k[0]));
         chk($sformatf("steady%0d exc", k),   33'(fifo_cheri_err_o), 33'(ex[k-1]));
         chk($sformatf("steady%0d busy", k),  33'(busy_o),       33'd1);
      end
      @(negedge clk_i);
      req_i = 1'b0; instr_gnt_i = 1'b0; instr_rvalid_i = 1'b1; instr_err_i = 1'b0;
      #1;
      chk("steady last valid", 33'(fifo_valid_o), 33'd1);
      chk("steady last exc",   33'(fifo_cheri_err_o), 33'(ex[6]));
      @(negedge clk_i);
      instr_rvalid_i = 1'b0;
      #1;
      chk("steady drained busy", 33'(busy_o), 33'd0);

      // reset with one request outstanding and another waiting for grant
      @(negedge clk_i);
      req_i = 1'b1; instr_gnt_i = 1'b1;
      #1;
      chk("midrst grant addr", 33'(instr_addr_o), 33'h5C);
      @(negedge clk_i);
      instr_gnt_i = 1'b0;
      #1;
      chk("midrst pend addr", 33'(instr_addr_o), 33'h60);
      @(negedge clk_i);
      rst_ni = 1'b0;
      @(negedge clk_i);
      rst_ni = 1'b1; req_i = 1'b0;
      #1;
      chk("midrst busy",  33'(busy_o),       33'd0);
      chk("midrst req",   33'(instr_req_o),  33'd0);
      chk("midrst addr",  33'(instr_addr_o), 33'd0);
      chk("midrst valid", 33'(fifo_valid_o), 33'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
